presence_filter: RTL and testbench

Downstream of the HC-SR04 controller: consumes its per-frame `trigger_o`, `object_detected` and `timeout_error` levels and turns them into a debounced presence signal. It applies:
- hysteresis, with consecutive-hit and consecutive-miss thresholds;
- error-run fault flagging;
- a stale-frame watchdog;
- an optional saturating count of presence events for the display/alarm logic.

---
 rtl/presence_filter.sv | 242 ++++++++++++++++++++++++
 tb/tb_presence_filter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/presence_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : presence_filter
//  Description : Debounces the per-frame result levels of an HC-SR04 ranging
//                controller into a presence signal. Applies hit/miss
//                hysteresis, flags runs of error frames, watches for frames
//                that stop arriving and optionally counts presence events.
//
//  Ports       : clk             - single clock, rising edge
//                rst_n           - asynchronous active-low reset
//                trig_i          - controller trigger (same clock domain)
//                det_i           - controller object_detected level
//                err_i           - controller timeout_error level
//                clr_count_i     - synchronous clear of the event counter
//                presence_o      - debounced presence
//                present_pulse_o - 1-cycle pulse when presence asserts
//                sample_valid_o  - 1-cycle pulse per accepted frame
//                fault_o         - error run reached ERR_LIMIT
//                stale_o         - no frame seen for STALE_MS
//                event_count_o   - saturating presence event count
//
//  Build macro : PRESENCE_EVENT_CNT_EN - when defined, the event counter and
//                clr_count_i are implemented; otherwise event_count_o is 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module presence_filter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int ON_COUNT   = 3,
    parameter int OFF_COUNT  = 5,
    parameter int ERR_LIMIT  = 4,
    parameter int STALE_MS   = 200,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_i,
    input  logic             det_i,
    input  logic             err_i,
    input  logic             clr_count_i,
    output logic             presence_o,
    output logic             present_pulse_o,
    output logic             sample_valid_o,
    output logic             fault_o,
    output logic             stale_o,
    output logic [CNT_W-1:0] event_count_o
);

    localparam logic [31:0] c_STALE_CYCLES = 32'((CLOCK_FREQ / 1000) * STALE_MS);

    localparam int c_HW = $clog2(ON_COUNT + 1);
    localparam int c_MW = $clog2(OFF_COUNT + 1);
    localparam int c_EW = $clog2(ERR_LIMIT + 1);

    localparam logic [c_HW-1:0] c_ON_COUNT  = c_HW'(ON_COUNT);
    localparam logic [c_MW-1:0] c_OFF_COUNT = c_MW'(OFF_COUNT);
    localparam logic [c_EW-1:0] c_ERR_LIMIT = c_EW'(ERR_LIMIT);

    localparam logic [1:0] c_ST_ARM     = 2'd0;
    localparam logic [1:0] c_ST_ABSENT  = 2'd1;
    localparam logic [1:0] c_ST_PRESENT = 2'd2;

    // Input capture
    logic trig_q;
    logic det_d1_q, det_d2_q;
    logic err_d1_q, err_d2_q;

    // Filter state
    logic [1:0]      state_q,    state_d;
    logic [c_HW-1:0] hit_cnt_q,  hit_cnt_d;
    logic [c_MW-1:0] miss_cnt_q, miss_cnt_d;
    logic [c_EW-1:0] err_cnt_q,  err_cnt_d;
    logic            presence_q, presence_d;
    logic            pulse_q,    pulse_d;
    logic            valid_q,    valid_d;
    logic            fault_q,    fault_d;
    logic            stale_q,    stale_d;
    logic [31:0]     wd_q,       wd_d;

    logic        w_edge;
    logic [31:0] w_wd_inc;
    logic        w_stale_fire;
    logic        w_pres_rise;

    assign w_edge   = trig_i & ~trig_q;
    assign w_wd_inc = (wd_q == 32'hFFFF_FFFF) ? wd_q : wd_q + 32'd1;
    // Fires only on the cycle the watchdog first arrives at the threshold;
    // once past it the counter keeps saturating without re-triggering.
    // A frame edge in the same cycle takes precedence.
    assign w_stale_fire = ~w_edge && (wd_q != c_STALE_CYCLES) && (w_wd_inc == c_STALE_CYCLES);

    // The controller drops its result one cycle before raising trigger, so
    // the frame's result is the value seen two cycles before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q   <= 1'b0;
            det_d1_q <= 1'b0;
            det_d2_q <= 1'b0;
            err_d1_q <= 1'b0;
            err_d2_q <= 1'b0;
        end else begin
            trig_q   <= trig_i;
            det_d1_q <= det_i;
            det_d2_q <= det_d1_q;
            err_d1_q <= err_i;
            err_d2_q <= err_d1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        presence_d  = presence_q;
        pulse_d     = 1'b0;
        valid_d     = 1'b0;
        fault_d     = fault_q;
        stale_d     = stale_q;
        wd_d        = w_edge ? 32'd0 : w_wd_inc;
        w_pres_rise = 1'b0;

        if (w_edge) begin
            stale_d = 1'b0;
            if (state_q == c_ST_ARM) begin
                // First frame after reset may be partial: discard it.
                state_d = c_ST_ABSENT;
            end else begin
                valid_d = 1'b1;
                if (err_d2_q) begin
                    // Error frames freeze hysteresis and only extend the run.
                    if (err_cnt_q != c_ERR_LIMIT) begin
                        err_cnt_d = err_cnt_q + c_EW'(1);
                    end
                    fault_d = (err_cnt_d == c_ERR_LIMIT);
                end else begin
                    err_cnt_d = '0;
                    fault_d   = 1'b0;
                    if (state_q == c_ST_ABSENT) begin
                        if (det_d2_q) begin
                            if (hit_cnt_q + c_HW'(1) == c_ON_COUNT) begin
                                state_d     = c_ST_PRESENT;
                                presence_d  = 1'b1;
                                pulse_d     = 1'b1;
                                w_pres_rise = 1'b1;
                                hit_cnt_d   = '0;
                            end else begin
                                hit_cnt_d = hit_cnt_q + c_HW'(1);
                            end
                        end else begin
                            hit_cnt_d = '0;
                        end
                    end else if (state_q == c_ST_PRESENT) begin
                        if (!det_d2_q) begin
                            if (miss_cnt_q + c_MW'(1) == c_OFF_COUNT) begin
                                state_d    = c_ST_ABSENT;
                                presence_d = 1'b0;
                                miss_cnt_d = '0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + c_MW'(1);
                            end
                        end else begin
                            miss_cnt_d = '0;
                        end
                    end else begin
                        // Unreachable encoding: fall back to a safe state.
                        state_d    = c_ST_ABSENT;
                        presence_d = 1'b0;
                        hit_cnt_d  = '0;
                        miss_cnt_d = '0;
                    end
                end
            end
        end else if (w_stale_fire) begin
            // Frames stopped arriving: drop presence, keep the fault flag.
            stale_d    = 1'b1;
            presence_d = 1'b0;
            state_d    = c_ST_ABSENT;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_ST_ARM;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_cnt_q  <= '0;
            presence_q <= 1'b0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            stale_q    <= 1'b0;
            wd_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_cnt_q  <= err_cnt_d;
            presence_q <= presence_d;
            pulse_q    <= pulse_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            stale_q    <= stale_d;
            wd_q       <= wd_d;
        end
    end

    assign presence_o      = presence_q;
    assign present_pulse_o = pulse_q;
    assign sample_valid_o  = valid_q;
    assign fault_o         = fault_q;
    assign stale_o         = stale_q;

`ifdef PRESENCE_EVENT_CNT_EN
    logic [CNT_W-1:0] evt_cnt_q;

    // Clear has priority over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_q <= '0;
        end else if (clr_count_i) begin
            evt_cnt_q <= '0;
        end else if (w_pres_rise && (evt_cnt_q != {CNT_W{1'b1}})) begin
            evt_cnt_q <= evt_cnt_q + CNT_W'(1);
        end
    end

    assign event_count_o = evt_cnt_q;
`else
    logic w_unused;

    assign w_unused      = clr_count_i & w_pres_rise;
    assign event_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_presence_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_presence_filter
//  Description : Self-checking bench for presence_filter. Frames are driven
//                with a known result, the two cycles before each edge carry
//                random junk, and a frame-level reference model predicts all
//                outputs every cycle. Honours PRESENCE_EVENT_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_presence_filter;

    localparam int CLOCK_FREQ = 100_000;
    localparam int ON_COUNT   = 3;
    localparam int OFF_COUNT  = 5;
    localparam int ERR_LIMIT  = 4;
    localparam int STALE_MS   = 2;
    localparam int CNT_W      = 2;
    localparam int STALE_CYC  = (CLOCK_FREQ / 1000) * STALE_MS;   // 200

    localparam int MISS = 0;
    localparam int HIT  = 1;
    localparam int ERR  = 2;

    typedef enum int {M_ARM, M_ABSENT, M_PRESENT} mstate_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             trig_i = 1'b0;
    logic             det_i = 1'b0;
    logic             err_i = 1'b0;
    logic             clr_count_i = 1'b0;
    logic             presence_o;
    logic             present_pulse_o;
    logic             sample_valid_o;
    logic             fault_o;
    logic             stale_o;
    logic [CNT_W-1:0] event_count_o;

    presence_filter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .ON_COUNT   (ON_COUNT),
        .OFF_COUNT  (OFF_COUNT),
        .ERR_LIMIT  (ERR_LIMIT),
        .STALE_MS   (STALE_MS),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trig_i          (trig_i),
        .det_i           (det_i),
        .err_i           (err_i),
        .clr_count_i     (clr_count_i),
        .presence_o      (presence_o),
        .present_pulse_o (present_pulse_o),
        .sample_valid_o  (sample_valid_o),
        .fault_o         (fault_o),
        .stale_o         (stale_o),
        .event_count_o   (event_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    mstate_t m_state;
    int      m_hit, m_miss, m_err, m_since, m_count;
    bit      m_presence, m_fault, m_stale, m_trig_prev;
    int      cur_cls;
    bit      rand_clr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h (pres,pulse,valid,fault,stale,count)",
                     tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return 32'({presence_o, present_pulse_o, sample_valid_o, fault_o, stale_o, event_count_o});
    endfunction

    task automatic model_reset();
        m_state     = M_ARM;
        m_hit       = 0;
        m_miss      = 0;
        m_err       = 0;
        m_since     = 0;
        m_count     = 0;
        m_presence  = 1'b0;
        m_fault     = 1'b0;
        m_stale     = 1'b0;
        m_trig_prev = 1'b0;
    endtask

    // One clock: predict the effect of the inputs now applied, clock, compare.
    task automatic clock_step(input string tag);
        bit             edge_now, e_pulse, e_valid;
        logic [CNT_W-1:0] e_cnt;
        e_pulse  = 1'b0;
        e_valid  = 1'b0;
        edge_now = trig_i && !m_trig_prev;
        m_trig_prev = trig_i;
        if (edge_now) begin
            m_since = 0;
            m_stale = 1'b0;
            if (m_state == M_ARM) begin
                m_state = M_ABSENT;
            end else begin
                e_valid = 1'b1;
                if (cur_cls == ERR) begin
                    m_err   = (m_err < ERR_LIMIT) ? m_err + 1 : ERR_LIMIT;
                    m_fault = (m_err == ERR_LIMIT);
                end else begin
                    m_err   = 0;
                    m_fault = 1'b0;
                    if (m_state == M_ABSENT) begin
                        m_hit = (cur_cls == HIT) ? m_hit + 1 : 0;
                        if (m_hit == ON_COUNT) begin
                            m_state    = M_PRESENT;
                            m_presence = 1'b1;
                            e_pulse    = 1'b1;
                            m_hit      = 0;
                            if (m_count < (1 << CNT_W) - 1) m_count++;
                        end
                    end else begin
                        m_miss = (cur_cls == MISS) ? m_miss + 1 : 0;
                        if (m_miss == OFF_COUNT) begin
                            m_state    = M_ABSENT;
                            m_presence = 1'b0;
                            m_miss     = 0;
                        end
                    end
                end
            end
        end else if (m_since < STALE_CYC) begin
            m_since++;
            if (m_since == STALE_CYC) begin
                m_stale    = 1'b1;
                m_presence = 1'b0;
                m_state    = M_ABSENT;
                m_hit      = 0;
                m_miss     = 0;
                m_err      = 0;
            end
        end
        if (clr_count_i) m_count = 0;
`ifdef PRESENCE_EVENT_CNT_EN
        e_cnt = CNT_W'(m_count);
`else
        e_cnt = '0;
`endif
        @(posedge clk);
        #1;
        check(tag, observed(),
              32'({m_presence, e_pulse, e_valid, m_fault, m_stale, e_cnt}));
    endtask

    task automatic drive_clr();
        clr_count_i = rand_clr && ($urandom_range(0, 15) == 0);
    endtask

    task automatic junk();
        det_i = 1'($urandom);
        err_i = 1'($urandom);
    endtask

    // One frame: result held for idle cycles, junk in the two cycles up to
    // and including the edge, trigger held for hold extra cycles.
    task automatic frame(input int cls, input int idle, input int hold, input bit clr_edge);
        cur_cls = cls;
        trig_i  = 1'b0;
        det_i   = (cls == HIT) ? 1'b1 : (cls == ERR) ? 1'($urandom) : 1'b0;
        err_i   = (cls == ERR);
        repeat (idle) begin
            drive_clr();
            clock_step("idle");
        end
        junk();
        drive_clr();
        clock_step("pre_edge");
        trig_i = 1'b1;
        junk();
        if (clr_edge) clr_count_i = 1'b1;
        else          drive_clr();
        clock_step("frame_edge");
        repeat (hold) begin
            junk();
            drive_clr();
            clock_step("trig_held");
        end
        trig_i      = 1'b0;
        clr_count_i = 1'b0;
    endtask

    task automatic frames(input int cls, input int n);
        for (int k = 0; k < n; k++) frame(cls, 3, 0, 1'b0);
    endtask

    // Reset asserted mid-cycle while the trigger is high; the trigger is
    // still high on release, so the first edge seen is the discarded one.
    task automatic reset_mid_frame();
        trig_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", observed(), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        clock_step("arm_after_reset");
        trig_i = 1'b0;
    endtask

    initial begin
        int r, idle;
        rand_clr = 1'b0;
        cur_cls  = MISS;
        model_reset();
        #1;
        check("reset_state", observed(), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        clock_step("after_reset");

        // Arm frame then three hits -> presence
        frame(HIT, 3, 0, 1'b0);
        frames(HIT, 3);
        // 4 misses, a hit, then 5 misses
        frames(MISS, 4);
        frames(HIT, 1);
        frames(MISS, 5);
        // Back to present, then an error run and a clearing miss
        frames(HIT, 3);
        frames(ERR, 5);
        frames(MISS, 1);
        frames(MISS, 3);
        // Held trigger produces a single frame
        frame(MISS, 2, 20, 1'b0);
        // Stale: gap exactly at threshold (edge wins), then one beyond it
        frame(HIT, 2, 0, 1'b0);
        frame(HIT, STALE_CYC - 2, 0, 1'b0);
        frame(HIT, STALE_CYC - 1, 0, 1'b0);
        frames(HIT, 3);
        frame(MISS, STALE_CYC + 20, 0, 1'b0);
        frames(MISS, 1);

        // Event counter saturation, then clear, then clear on increment
        for (int e = 0; e < 5; e++) begin
            frames(HIT, 3);
            frames(MISS, 5);
        end
        frame(MISS, 3, 0, 1'b1);
        frames(HIT, 3);
        frames(MISS, 5);
        frames(HIT, 2);
        frame(HIT, 3, 0, 1'b1);

        // Reset while present and mid-frame
        reset_mid_frame();
        frames(HIT, 3);

        // Randomized frames
        rand_clr = 1'b1;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset_mid_frame();
            end else begin
                idle = ($urandom_range(0, 99) < 4)
                       ? STALE_CYC - 4 + $urandom_range(0, 30)
                       : $urandom_range(1, 12);
                r = $urandom_range(0, 99);
                frame((r < 45) ? HIT : (r < 82) ? MISS : ERR, idle,
                      $urandom_range(0, 3), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
